// File: rtl/bus_ram_controller.sv
// Word-addressed 32-bit RAM behind a simple request/valid bus, with WAIT_STATES idle cycles per access.
// Define RAM_RANGE_CHECK_EN to flag out-of-range word indices on bus_error instead of wrapping them.
module bus_ram_controller #(
  parameter int unsigned WAIT_STATES  = 2,
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_address,
  input  logic [31:0] bus_write_data,
  input  logic [3:0]  bus_byte_enable,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  output logic [31:0] bus_read_data,
  output logic        bus_wait_req,
  output logic        bus_valid
`ifdef RAM_RANGE_CHECK_EN
  , output logic      bus_error
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        write_q;
  logic        valid_q;
  logic [31:0] rdata_q;
  logic [31:0] mem [2**ADDR_WIDTH];

  logic                  req;
  logic [31:0]           txn_addr, txn_wdata, offset;
  logic [3:0]            txn_be;
  logic                  txn_write;
  logic                  commit;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] widx;
  logic                  unused_bits;

  assign req = bus_read_enable | bus_write_enable;

  // With zero wait states the access completes on the sampling edge, so the
  // live bus fields are used in IDLE and the latched copies afterwards.
  always_comb begin
    if (state_q == S_IDLE) begin
      txn_addr  = bus_address;
      txn_wdata = bus_write_data;
      txn_be    = bus_byte_enable;
      txn_write = bus_write_enable;
    end else begin
      txn_addr  = addr_q;
      txn_wdata = wdata_q;
      txn_be    = be_q;
      txn_write = write_q;
    end
    offset = txn_addr - BASE_ADDRESS;
    widx   = offset[ADDR_WIDTH+1:2];
`ifdef RAM_RANGE_CHECK_EN
    in_range = (offset[31:2] >> ADDR_WIDTH) == '0;
`else
    in_range = 1'b1;
`endif
    commit = ((state_q == S_IDLE) && req && (WAIT_STATES == 0)) ||
             ((state_q == S_WAIT) && (cnt_q == 4'd1));
  end

  assign unused_bits = ^{offset[1:0], offset[31:ADDR_WIDTH+2]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      valid_q <= commit;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            addr_q  <= bus_address;
            wdata_q <= bus_write_data;
            be_q    <= bus_byte_enable;
            write_q <= bus_write_enable;
            if (WAIT_STATES == 0) begin
              state_q <= S_RESPOND;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 4'(WAIT_STATES);
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= S_RESPOND;
        end
        S_RESPOND: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
      if (commit && !txn_write) rdata_q <= in_range ? mem[widx] : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && commit && txn_write && in_range) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (txn_be[i]) mem[widx][8*i +: 8] <= txn_wdata[8*i +: 8];
      end
    end
  end

`ifdef RAM_RANGE_CHECK_EN
  logic error_q;
  always_ff @(posedge clock) begin
    if (reset) error_q <= 1'b0;
    else       error_q <= commit && !in_range;
  end
  assign bus_error = error_q;
`endif

  assign bus_read_data = rdata_q;
  assign bus_valid     = valid_q;
  assign bus_wait_req  = ((state_q != S_IDLE) || req) && !valid_q;

endmodule

// File: tb/tb_bus_ram_controller.sv
// Bench for bus_ram_controller: two instances (2 and 0 wait states) against a word-array reference model.
// Honours RAM_RANGE_CHECK_EN when defined at compile time.
module tb_bus_ram_controller;

  localparam int unsigned WS0 = 2, WS1 = 0, AW0 = 14, AW1 = 10;
  localparam logic [31:0] BASE0 = 32'h0000_0000, BASE1 = 32'h0000_1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wd_s    [2];
  logic [3:0]  be_s    [2];
  logic        rd_s    [2];
  logic        wr_s    [2];
  logic [31:0] rdata_s [2];
  logic        wreq_s  [2];
  logic        valid_s [2];
`ifdef RAM_RANGE_CHECK_EN
  logic        err_s   [2];
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] exp_rd [2];

  bus_ram_controller #(.WAIT_STATES(WS0), .ADDR_WIDTH(AW0), .BASE_ADDRESS(BASE0)) dut0 (
    .clock(clk), .reset(rst[0]), .bus_address(addr_s[0]), .bus_write_data(wd_s[0]),
    .bus_byte_enable(be_s[0]), .bus_read_enable(rd_s[0]), .bus_write_enable(wr_s[0]),
    .bus_read_data(rdata_s[0]), .bus_wait_req(wreq_s[0]), .bus_valid(valid_s[0])
`ifdef RAM_RANGE_CHECK_EN
    , .bus_error(err_s[0])
`endif
  );

  bus_ram_controller #(.WAIT_STATES(WS1), .ADDR_WIDTH(AW1), .BASE_ADDRESS(BASE1)) dut1 (
    .clock(clk), .reset(rst[1]), .bus_address(addr_s[1]), .bus_write_data(wd_s[1]),
    .bus_byte_enable(be_s[1]), .bus_read_enable(rd_s[1]), .bus_write_enable(wr_s[1]),
    .bus_read_data(rdata_s[1]), .bus_wait_req(wreq_s[1]), .bus_valid(valid_s[1])
`ifdef RAM_RANGE_CHECK_EN
    , .bus_error(err_s[1])
`endif
  );

  function automatic int unsigned ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction
  function automatic int unsigned aw_of(input int d);
    return (d == 0) ? AW0 : AW1;
  endfunction
  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? BASE0 : BASE1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete bus access: model update, request phase, wait phase with junk inputs, response, idle.
  task automatic txn(input int d, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] widx, w;
    logic        oor;
    int unsigned key;
    widx = (a - base_of(d)) >> 2;
`ifdef RAM_RANGE_CHECK_EN
    oor = (widx >= (32'd1 << aw_of(d)));
`else
    oor = 1'b0;
`endif
    key = 32'(d) * 32'h0010_0000 + (widx % (32'd1 << aw_of(d)));
    if (wr) begin
      if (!oor) begin
        w = ref_mem[key];
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
        ref_mem[key] = w;
      end
    end else if (rd) begin
      exp_rd[d] = oor ? 32'h0 : ref_mem[key];
    end

    @(negedge clk);
    rd_s[d] = rd; wr_s[d] = wr; addr_s[d] = a; wd_s[d] = wd; be_s[d] = be;
    #1;
    chk("wait_req_at_request", 32'(wreq_s[d]), 32'd1);
    chk("valid_at_request", 32'(valid_s[d]), 32'd0);
    @(posedge clk);
    for (int unsigned k = 0; k < ws_of(d); k++) begin
      @(negedge clk);
      chk("valid_in_wait", 32'(valid_s[d]), 32'd0);
      chk("wait_req_in_wait", 32'(wreq_s[d]), 32'd1);
      rd_s[d] = 1'($urandom_range(0, 1)); wr_s[d] = 1'($urandom_range(0, 1));
      addr_s[d] = $urandom; wd_s[d] = $urandom; be_s[d] = 4'($urandom);
    end
    @(negedge clk);
    chk("valid_at_response", 32'(valid_s[d]), 32'd1);
    chk("wait_req_at_response", 32'(wreq_s[d]), 32'd0);
    chk("read_data_at_response", rdata_s[d], exp_rd[d]);
`ifdef RAM_RANGE_CHECK_EN
    chk("error_at_response", 32'(err_s[d]), 32'(oor));
`endif
    rd_s[d] = 1'b0; wr_s[d] = 1'b0;
    @(negedge clk);
    chk("valid_after_response", 32'(valid_s[d]), 32'd0);
    chk("wait_req_after_response", 32'(wreq_s[d]), 32'd0);
    chk("read_data_held", rdata_s[d], exp_rd[d]);
  endtask

  function automatic logic [31:0] rand_addr(input int d);
    logic [31:0] alias_step;
    alias_step = 32'd4 << aw_of(d);
    return base_of(d) + 32'($urandom_range(0, 31)) * 32'd4
           + 32'($urandom_range(0, 1)) * alias_step + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] hold_val;
    int          kind;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rd_s[d] = 1'b0; wr_s[d] = 1'b0;
      addr_s[d] = '0; wd_s[d] = '0; be_s[d] = '0; exp_rd[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_valid", 32'(valid_s[d]), 32'd0);
      chk("reset_read_data", rdata_s[d], 32'd0);
      chk("reset_wait_req", 32'(wreq_s[d]), 32'd0);
`ifdef RAM_RANGE_CHECK_EN
      chk("reset_error", 32'(err_s[d]), 32'd0);
`endif
      rst[d] = 1'b0;
    end

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++)
        txn(d, 1'b0, 1'b1, base_of(d) + 32'(i) * 32'd4, $urandom, 4'hF);

    txn(0, 1'b0, 1'b1, 32'h10, 32'hCAFE_BABE, 4'hF);
    txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("write_then_read_0x10", rdata_s[0], 32'hCAFE_BABE);

    txn(0, 1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
    txn(0, 1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
    txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    chk("byte_lane_merge_0x20", rdata_s[0], 32'h11BB_33DD);

    txn(0, 1'b1, 1'b1, 32'h8, 32'h5, 4'hF);
    chk("read_write_together_rdata", rdata_s[0], 32'h11BB_33DD);
    txn(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    chk("read_write_together_mem", rdata_s[0], 32'h5);

    txn(0, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 4'h0);

    // Reset lands while the write to 0x40 is still waiting.
    @(negedge clk);
    wr_s[0] = 1'b1; addr_s[0] = 32'h40; wd_s[0] = 32'hDEAD_BEEF; be_s[0] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b1; wr_s[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(valid_s[0]), 32'd0);
      chk("abort_read_data", rdata_s[0], 32'd0);
      chk("abort_wait_req", 32'(wreq_s[0]), 32'd0);
    end
    rst[0] = 1'b0;
    exp_rd[0] = '0;
    txn(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);

    // Zero wait states with read held: one response every second cycle.
    hold_val = ref_mem[32'h0010_0000 + 32'd5];
    @(negedge clk);
    rd_s[1] = 1'b1; addr_s[1] = BASE1 + 32'd20;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stream_valid", 32'(valid_s[1]), 32'(i % 2 == 0));
      chk("stream_wait_req", 32'(wreq_s[1]), 32'(i % 2 == 1));
      if (i % 2 == 0) chk("stream_read_data", rdata_s[1], hold_val);
    end
    rd_s[1] = 1'b0;
    exp_rd[1] = hold_val;
    @(negedge clk);
    chk("stream_stop_valid", 32'(valid_s[1]), 32'd0);
    chk("stream_stop_wait_req", 32'(wreq_s[1]), 32'd0);

    for (int n = 0; n < 80; n++) begin
      int d;
      d = n % 2;
      kind = int'($urandom_range(0, 3));
      txn(d, (kind != 1), (kind == 1 || kind == 2), rand_addr(d), $urandom, 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_ram_controller.md
BUS_RAM_CONTROLLER -- requirements
Module: bus_ram_controller

Interface
REQ-001 Parameter WAIT_STATES, default 2, number of idle cycles inserted between request sampling and response (0..15).
REQ-002 Parameter ADDR_WIDTH, default 14, word-address width; memory holds 2^ADDR_WIDTH 32-bit words.
REQ-003 Parameter BASE_ADDRESS, default 32'h0000_0000, byte address of word 0.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 bus_address  input  32  byte address from core; bits [1:0] ignored.
REQ-007 bus_write_data  input  32  store data, lane-aligned.
REQ-008 bus_byte_enable  input  4  per-lane write enables; bit i covers bits [8i+7:8i].
REQ-009 bus_read_enable  input  1  read request.
REQ-010 bus_write_enable  input  1  write request.
REQ-011 bus_read_data  output  32  registered read response.
REQ-012 bus_wait_req  output  1  transaction in progress, response not yet given.
REQ-013 bus_valid  output  1  one-cycle response strobe.
REQ-014 bus_error  output  1  present only with RAM_RANGE_CHECK_EN; out-of-range strobe.

Function
REQ-015 FSM states: IDLE, WAIT, RESPOND.
REQ-016 IDLE with bus_read_enable or bus_write_enable high: latch address, write data, byte enables and kind; go to WAIT with counter=WAIT_STATES, or RESPOND directly if WAIT_STATES==0.
REQ-017 WAIT: counter decrements each cycle; at counter==1 next state is RESPOND.
REQ-018 Latency: request sampled at edge N; bus_valid high during cycle N+WAIT_STATES+1, exactly one cycle.
REQ-019 Writes commit to memory on the edge entering RESPOND, only lanes with byte enable set.
REQ-020 Reads load bus_read_data on the edge entering RESPOND; bus_read_data holds until the next read response.
REQ-021 RESPOND always returns to IDLE; a request still asserted in IDLE is sampled as a new transaction (back-to-back throughput 1 per WAIT_STATES+2 cycles).
REQ-022 bus_wait_req = (state!=IDLE or any request high) and not bus_valid.
REQ-023 Read and write asserted together: treated as write; bus_read_data unchanged.
REQ-024 Requests dropped or changed during WAIT are ignored; latched transaction completes.
REQ-025 Word index = (bus_address - BASE_ADDRESS) >> 2, modulo 32-bit arithmetic.
REQ-026 Read following a write to the same word returns the written data.

Reset
REQ-027 Reset: state IDLE, counter 0, bus_valid 0, bus_read_data 0, bus_error 0.
REQ-028 Reset mid-transaction aborts it; pending write not committed; no bus_valid issued.
REQ-029 Memory contents are not cleared by reset.

Configuration
REQ-030 Macro RAM_RANGE_CHECK_EN: when defined, indices >= 2^ADDR_WIDTH are out of range; writes are dropped, reads return 32'h0000_0000, bus_error pulses with bus_valid.
REQ-031 Without RAM_RANGE_CHECK_EN: index truncated to ADDR_WIDTH bits (wrap-around); bus_error port absent.

Verification
REQ-032 Write 32'hCAFE_BABE to 0x10 with be 4'hF, WAIT_STATES=2 -> bus_valid in third cycle after sampling; read 0x10 returns 32'hCAFE_BABE.
REQ-033 Word 0x20 = 32'h1122_3344, write 32'hAABB_CCDD with be 4'b0101 -> read returns 32'h11BB_33DD.
REQ-034 WAIT_STATES=0, read held high continuously -> bus_valid every second cycle, bus_wait_req low only in valid cycles.
REQ-035 Reset asserted in WAIT of write to 0x40 -> no bus_valid, later read of 0x40 returns prior contents.
REQ-036 RAM_RANGE_CHECK_EN, ADDR_WIDTH=14, read 0x0001_0000 -> data 0, bus_error with bus_valid; without macro same access aliases word 0.
REQ-037 Read and write both high at 0x8 with data 32'h5 -> memory word 2 = 32'h5, bus_read_data unchanged.
